uart_rx_param: RTL and testbench

Parametrised UART receiver, successor to the fixed 8-bit/parity receiver.
- Configurable data width, runtime parity mode (none/even/odd), 1 or 2 stop bits.
- Oversampled mid-bit sampling with false-start rejection.
- Valid/ready output with per-word parity, framing and overrun status.
- Sits between the rx pad synchroniser path and the consumer (register file or FIFO); the baud divisor is driven from the existing baud selection logic.

---
 rtl/uart_rx_pkg.sv | 29 ++
 rtl/uart_rx_baud_tick.sv | 35 +++
 rtl/uart_rx_param.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the parametrised UART receiver
`timescale 1ns/1ps
package uart_rx_pkg;

  // Runtime parity selection; the unused code 2'b11 also means no parity.
  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_mode_t;

  // Receiver FSM states.
  typedef logic [2:0] state_t;
  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;
  localparam state_t BREAK  = 3'd5;

  // Mid-bit sample position within an oversampled bit.
  function automatic int mid_sample(input int oversample);
    return oversample / 2;
  endfunction

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int MID_SAMPLE         = mid_sample(OVERSAMPLE_DEFAULT);

endpackage

// File: rtl/uart_rx_baud_tick.sv
// rtl/uart_rx_baud_tick.sv - oversample tick generator with idle-time divisor load
`timescale 1ns/1ps
module uart_rx_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] baud_div_q;

  // Divisor is only taken while the receiver is idle; counter wraps at the divisor.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      baud_div_q <= '0;
    end else begin
      if (load) begin
        baud_div_q <= baud_div;
      end
      if (cnt >= baud_div_q) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

  assign tick = (cnt == baud_div_q);

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver; optional UART_RX_MAJORITY_EN 2-of-3 vote
`timescale 1ns/1ps
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop_bits,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int SCNT_W   = $clog2(OVERSAMPLE);
  localparam int MID_TICK = mid_sample(OVERSAMPLE);
  localparam logic [SCNT_W-1:0] LAST_TICK = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [3:0]        LAST_BIT  = 4'(DATA_BITS - 1);

  logic                 sync1, line;
  logic                 tick;
  state_t               state;
  logic [SCNT_W-1:0]    s_cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] data_sr;
  logic                 par_err_r, frm_err_r;
  logic                 done_q;
  logic [1:0]           parity_mode_q;
  logic                 stop_bits_q;
  logic                 bit_val;
  logic                 at_dec;
  logic                 parity_en;

  // Two-flop synchroniser on the asynchronous serial line, idling high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      line  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      line  <= sync1;
    end
  end

  uart_rx_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .load     (state == IDLE),
    .baud_div (baud_div),
    .tick     (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam logic [SCNT_W-1:0] DEC_TICK = SCNT_W'(MID_TICK + 1);
  logic vote_a, vote_b;

  // Hold the two samples preceding the decision tick for the 2-of-3 vote.
  always_ff @(posedge clk) begin
    if (reset) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else if (tick) begin
      if (s_cnt == SCNT_W'(MID_TICK - 1)) vote_a <= line;
      if (s_cnt == SCNT_W'(MID_TICK))     vote_b <= line;
    end
  end

  assign bit_val = (vote_a & vote_b) | (vote_a & line) | (vote_b & line);
`else
  localparam logic [SCNT_W-1:0] DEC_TICK = SCNT_W'(MID_TICK);
  assign bit_val = line;
`endif

  assign at_dec    = (s_cnt == DEC_TICK);
  assign parity_en = (parity_mode_q == PAR_EVEN) || (parity_mode_q == PAR_ODD);
  assign busy      = (state != IDLE);

  // Frame FSM: the sample counter free-runs across bits from the start edge, so
  // every state decides at the same point of its own bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      s_cnt         <= '0;
      bit_idx       <= '0;
      stop_idx      <= 1'b0;
      data_sr       <= '0;
      par_err_r     <= 1'b0;
      frm_err_r     <= 1'b0;
      done_q        <= 1'b0;
      parity_mode_q <= 2'b00;
      stop_bits_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        parity_mode_q <= parity_mode;
        stop_bits_q   <= stop_bits;
      end
      if (tick) begin
        if (state != IDLE) begin
          s_cnt <= (s_cnt == LAST_TICK) ? '0 : s_cnt + SCNT_W'(1);
        end
        case (state)
          IDLE: begin
            if (!line) begin
              state     <= START;
              s_cnt     <= '0;
              par_err_r <= 1'b0;
              frm_err_r <= 1'b0;
            end
          end
          START: begin
            if (at_dec) begin
              state   <= bit_val ? IDLE : DATA;
              bit_idx <= '0;
            end
          end
          DATA: begin
            if (at_dec) begin
              data_sr <= {bit_val, data_sr[DATA_BITS-1:1]};
              bit_idx <= bit_idx + 4'd1;
              if (bit_idx == LAST_BIT) begin
                state    <= parity_en ? PARITY : STOP;
                stop_idx <= 1'b0;
              end
            end
          end
          PARITY: begin
            if (at_dec) begin
              par_err_r <= (parity_mode_q == PAR_ODD) ? ~(^data_sr ^ bit_val)
                                                      :  (^data_sr ^ bit_val);
              state     <= STOP;
            end
          end
          STOP: begin
            if (at_dec) begin
              if (!bit_val) frm_err_r <= 1'b1;
              if (stop_bits_q && !stop_idx) begin
                stop_idx <= 1'b1;
              end else begin
                done_q <= 1'b1;
                state  <= bit_val ? IDLE : BREAK;
              end
            end
          end
          BREAK: begin
            if (line) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Output holding register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (done_q && (!rx_valid || rx_ready)) begin
      rx_valid   <= 1'b1;
      rx_data    <= data_sr;
      parity_err <= par_err_r;
      frame_err  <= frm_err_r;
      overrun    <= 1'b0;
    end else if (done_q) begin
      overrun <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int DIV_W      = 16;
  localparam int BIT_CLK    = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [DIV_W-1:0]     baud_div = '0;
  logic [1:0]           parity_mode = 2'b00;
  logic                 stop_bits = 1'b0;
  logic                 rx_in = 1'b1;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready = 1'b1;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Each accepted word as {data, parity_err, frame_err}.
  logic [9:0] cap_q[$];

  uart_rx_param #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_div   (baud_div),
    .parity_mode(parity_mode),
    .stop_bits  (stop_bits),
    .rx_in      (rx_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && rx_valid && rx_ready) cap_q.push_back({rx_data, parity_err, frame_err});
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx_in = v;
    cycles(n);
  endtask

  function automatic logic [9:0] model(input logic [7:0] d, input logic [1:0] mode,
                                       input logic pbit, input logic two,
                                       input logic s1, input logic s2);
    int   ones;
    logic perr, ferr;
    ones = $countones(d) + int'(pbit);
    if (mode == 2'b01)      perr = (ones % 2) == 1;
    else if (mode == 2'b10) perr = (ones % 2) == 0;
    else                    perr = 1'b0;
    ferr = !s1 || (two && !s2);
    return {d, perr, ferr};
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic [1:0] mode, input logic pbit,
                            input logic two, input logic s1, input logic s2, input int gap);
    parity_mode = mode;
    stop_bits   = two;
    drive(1'b0, BIT_CLK);
    for (int i = 0; i < DATA_BITS; i++) drive(d[i], BIT_CLK);
    if (mode == 2'b01 || mode == 2'b10) drive(pbit, BIT_CLK);
    drive(s1, BIT_CLK);
    if (two) drive(s2, BIT_CLK);
    drive(1'b1, gap);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycles(3);
    chk_cnt++;
    if ({rx_valid, parity_err, frame_err, overrun, busy} !== 5'b0) begin
      $display("FAIL reset_flags: got %b expected 00000", {rx_valid, parity_err, frame_err, overrun, busy});
    end else pass_cnt++;
    chk_cnt++;
    if (rx_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", rx_data);
    else pass_cnt++;
    reset = 1'b0;
    cycles(4);
  endtask

  task automatic test_even_parity();
    logic [9:0] exp, got;
    cap_q.delete();
    send_frame(8'hA5, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 10);
    cycles(4);
    exp = model(8'hA5, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_cnt++;
    if (cap_q.size() !== 1) $display("FAIL even_count: got %0d expected 1", cap_q.size());
    else pass_cnt++;
    got = (cap_q.size() > 0) ? cap_q[0] : 'x;
    chk_cnt++;
    if (got !== exp) $display("FAIL even_word: got %h expected %h", got, exp);
    else pass_cnt++;
  endtask

  task automatic test_odd_parity_error();
    logic [9:0] exp, got;
    cap_q.delete();
    send_frame(8'h3C, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 10);
    cycles(4);
    exp = model(8'h3C, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
    got = (cap_q.size() > 0) ? cap_q[0] : 'x;
    chk_cnt++;
    if (got !== exp) $display("FAIL odd_word: got %h expected %h", got, exp);
    else pass_cnt++;
  endtask

  task automatic test_break();
    logic [9:0] exp, got;
    cap_q.delete();
    send_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    drive(1'b0, 24);
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL break_busy: got %b expected 1", busy);
    else pass_cnt++;
    drive(1'b1, 10);
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL break_exit: got %b expected 0", busy);
    else pass_cnt++;
    exp = model(8'h55, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    got = (cap_q.size() > 0) ? cap_q[0] : 'x;
    chk_cnt++;
    if (got !== exp) $display("FAIL break_word: got %h expected %h", got, exp);
    else pass_cnt++;
    cap_q.delete();
    send_frame(8'h0F, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 10);
    cycles(4);
    exp = model(8'h0F, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    got = (cap_q.size() > 0) ? cap_q[0] : 'x;
    chk_cnt++;
    if (got !== exp) $display("FAIL after_break_word: got %h expected %h", got, exp);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    cap_q.delete();
    drive(1'b0, 4);
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL glitch_start: got %b expected 1", busy);
    else pass_cnt++;
    drive(1'b1, 30);
    chk_cnt++;
    if ({busy, rx_valid} !== 2'b00) $display("FAIL glitch_reject: got %b expected 00", {busy, rx_valid});
    else pass_cnt++;
    chk_cnt++;
    if (cap_q.size() !== 0) $display("FAIL glitch_words: got %0d expected 0", cap_q.size());
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    cap_q.delete();
    rx_ready = 1'b0;
    send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 4);
    send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 6);
    chk_cnt++;
    if ({rx_valid, overrun} !== 2'b11) $display("FAIL overrun_flags: got %b expected 11", {rx_valid, overrun});
    else pass_cnt++;
    chk_cnt++;
    if (rx_data !== 8'h11) $display("FAIL overrun_hold: got %h expected 11", rx_data);
    else pass_cnt++;
    rx_ready = 1'b1;
    cycles(1);
    chk_cnt++;
    if ({rx_valid, overrun} !== 2'b00) $display("FAIL overrun_clear: got %b expected 00", {rx_valid, overrun});
    else pass_cnt++;
    chk_cnt++;
    if (cap_q.size() !== 1 || cap_q[0][9:2] !== 8'h11) begin
      $display("FAIL overrun_transfer: got %0d words expected one word of 11", cap_q.size());
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    logic [9:0] exp, got;
    cap_q.delete();
    d = 8'h99;
    parity_mode = 2'b00;
    stop_bits   = 1'b0;
    drive(1'b0, BIT_CLK);
    for (int i = 0; i < 3; i++) drive(d[i], BIT_CLK);
    drive(d[3], 8);
    reset = 1'b1;
    cycles(1);
    chk_cnt++;
    if ({rx_valid, parity_err, frame_err, overrun, busy} !== 5'b0 || rx_data !== 8'h00) begin
      $display("FAIL midreset_outputs: got %b/%h expected 00000/00",
               {rx_valid, parity_err, frame_err, overrun, busy}, rx_data);
    end else pass_cnt++;
    reset = 1'b0;
    drive(1'b1, 200);
    chk_cnt++;
    if (cap_q.size() !== 0) $display("FAIL midreset_words: got %0d expected 0", cap_q.size());
    else pass_cnt++;
    send_frame(8'h66, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 10);
    cycles(4);
    exp = model(8'h66, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
    got = (cap_q.size() > 0) ? cap_q[0] : 'x;
    chk_cnt++;
    if (got !== exp) $display("FAIL two_stop_word: got %h expected %h", got, exp);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [9:0] exp_q[$];
    logic [9:0] got;
    logic [7:0] d;
    logic [1:0] mode;
    logic       pbit, two, s1, s2;
    cap_q.delete();
    for (int n = 0; n < 12; n++) begin
      d    = 8'($urandom_range(0, 255));
      mode = 2'($urandom_range(0, 3));
      pbit = 1'($urandom_range(0, 1));
      two  = 1'($urandom_range(0, 1));
      s1   = ($urandom_range(0, 4) != 0);
      s2   = ($urandom_range(0, 4) != 0);
      exp_q.push_back(model(d, mode, pbit, two, s1, s2));
      send_frame(d, mode, pbit, two, s1, s2, $urandom_range(1, 8));
    end
    cycles(6);
    chk_cnt++;
    if (cap_q.size() !== exp_q.size()) $display("FAIL random_count: got %0d expected %0d", cap_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : 'x;
      chk_cnt++;
      if (got !== exp_q[i]) $display("FAIL random_word%0d: got %h expected %h", i, got, exp_q[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_even_parity();
    test_odd_parity_error();
    test_break();
    test_glitch();
    test_overrun();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
